// File: rtl/boot_loader_ctrl.sv
// Program-load sequencer: length-prefixed byte stream -> 32-bit program RAM writes, CPU held in reset until loaded.
// Optional trailing checksum byte enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_loader_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  boot_req,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int unsigned           IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0]     IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]           MAX_WORDS = 17'(1 << ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t      state, state_next;
    logic        accept;
    logic        timed;
    logic        timeout;
    logic        last_word;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [16:0] length_rx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [IDLE_W-1:0] idle_cnt;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    assign accept    = rx_valid && rx_ready;
    assign length_rx = {1'b0, rx_data, len_lo};
    assign last_word = ((17'(word_count) + 17'd1) == {1'b0, len});
`ifdef BOOT_LOADER_CHECKSUM_EN
    assign timed     = (state == S_LEN1) || (state == S_DATA) || (state == S_CHK);
`else
    assign timed     = (state == S_LEN1) || (state == S_DATA);
`endif
    assign timeout   = timed && !accept && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_LEN0;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (boot_req) begin
            state_next = S_LEN0;
        end else begin
            case (state)
                S_LEN0: if (accept) state_next = S_LEN1;
                S_LEN1: begin
                    if (accept) begin
                        if (length_rx == 17'd0)          state_next = S_DONE;
                        else if (length_rx > MAX_WORDS)  state_next = S_ERROR;
                        else                             state_next = S_DATA;
                    end else if (timeout) begin
                        state_next = S_ERROR;
                    end
                end
                S_DATA: begin
                    if (accept && byte_idx == 2'd3 && last_word) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        state_next = S_CHK;
`else
                        state_next = S_DONE;
`endif
                    end else if (timeout) begin
                        state_next = S_ERROR;
                    end
                end
`ifdef BOOT_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept)       state_next = (rx_data == checksum) ? S_DONE : S_ERROR;
                    else if (timeout) state_next = S_ERROR;
                end
`endif
                S_DONE:  state_next = S_RUN;
                S_RUN:   state_next = S_RUN;
                S_ERROR: state_next = S_ERROR;
                default: state_next = S_LEN0;
            endcase
        end
    end

    always_comb begin
        rx_ready  = 1'b0;
        busy      = 1'b0;
        cpu_reset = 1'b1;
        case (state)
            S_LEN0:  rx_ready = 1'b1;
            S_LEN1:  begin rx_ready = 1'b1; busy = 1'b1; end
            S_DATA:  begin rx_ready = 1'b1; busy = 1'b1; end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHK:   begin rx_ready = 1'b1; busy = 1'b1; end
`endif
            S_DONE:  busy = 1'b1;
            S_RUN:   cpu_reset = 1'b0;
            S_ERROR: rx_ready = 1'b1;
            default: ;
        endcase
    end

    // Bytes shift in from the top so the first byte lands in bits [7:0] once the word completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            word_count <= '0;
            error      <= 1'b0;
            len_lo     <= '0;
            len        <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            idle_cnt   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            ram_we <= 1'b0;
            if (boot_req) begin
                ram_addr   <= '0;
                word_count <= '0;
                error      <= 1'b0;
                len_lo     <= '0;
                len        <= '0;
                byte_idx   <= '0;
                word_buf   <= '0;
                idle_cnt   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                checksum   <= '0;
`endif
            end else begin
                if (timed && !accept) idle_cnt <= idle_cnt + IDLE_W'(1);
                else                  idle_cnt <= '0;

                if (state_next == S_ERROR && state != S_ERROR) error <= 1'b1;

                if (accept) begin
                    case (state)
                        S_LEN0: len_lo <= rx_data;
                        S_LEN1: len    <= {rx_data, len_lo};
                        S_DATA: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                            checksum <= checksum + rx_data;
`endif
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                ram_we     <= 1'b1;
                                ram_addr   <= word_count[ADDR_WIDTH-1:0];
                                ram_wdata  <= {rx_data, word_buf};
                                word_count <= word_count + (ADDR_WIDTH+1)'(1);
                            end else begin
                                word_buf <= {rx_data, word_buf[23:8]};
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed testbench for boot_loader_ctrl (ADDR_WIDTH=8, TIMEOUT_CYCLES=16); follows BOOT_LOADER_CHECKSUM_EN if defined.
module tb_boot_loader_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        boot_req;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        error;
    logic [8:0]  word_count;

    int checks   = 0;
    int errors   = 0;
    int we_count = 0;

    boot_loader_ctrl #(
        .ADDR_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .boot_req  (boot_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .error     (error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ram_we === 1'b1) we_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_boot();
        boot_req = 1'b1;
        @(posedge clk);
        #1;
        boot_req = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
        check({tag, "_rx_ready"},   32'(rx_ready),   32'd1);
        check({tag, "_ram_we"},     32'(ram_we),     32'd0);
        check({tag, "_ram_addr"},   32'(ram_addr),   32'd0);
        check({tag, "_ram_wdata"},  ram_wdata,       32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        boot_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check_reset("por");
        #11;
        reset_n = 1'b1;
        idle(1);

        // Two-word image
        send(8'h02); send(8'h00);
        check("len_busy", 32'(busy), 32'd1);
        send(8'h78); send(8'h56); send(8'h34);
        check("w0_pre_we", 32'(ram_we), 32'd0);
        send(8'h12);
        check("w0_we",    32'(ram_we),     32'd1);
        check("w0_addr",  32'(ram_addr),   32'd0);
        check("w0_data",  ram_wdata,       32'h12345678);
        check("w0_count", 32'(word_count), 32'd1);
        send(8'hEF); send(8'hBE); send(8'hAD);
        check("w1_ready", 32'(rx_ready), 32'd1);
        send(8'hDE);
        check("w1_we",    32'(ram_we),     32'd1);
        check("w1_addr",  32'(ram_addr),   32'd1);
        check("w1_data",  ram_wdata,       32'hDEADBEEF);
        check("w1_count", 32'(word_count), 32'd2);
`ifdef BOOT_LOADER_CHECKSUM_EN
        check("chk_cpu_reset", 32'(cpu_reset), 32'd1);
        send(8'h4C);
        check("done_we", 32'(ram_we), 32'd0);
`endif
        check("done_cpu_reset", 32'(cpu_reset), 32'd1);
        check("done_busy",      32'(busy),      32'd1);
        idle(1);
        check("run_cpu_reset", 32'(cpu_reset),  32'd0);
        check("run_rx_ready",  32'(rx_ready),   32'd0);
        check("run_busy",      32'(busy),       32'd0);
        check("run_count",     32'(word_count), 32'd2);
        check("run_error",     32'(error),      32'd0);
        check("run_we_total",  32'(we_count),   32'd2);

        // boot_req while running
        pulse_boot();
        check("rb_cpu_reset", 32'(cpu_reset),  32'd1);
        check("rb_count",     32'(word_count), 32'd0);
        check("rb_rx_ready",  32'(rx_ready),   32'd1);

        // Zero-length image
        send(8'h00); send(8'h00);
        check("n0_cpu_reset_hold", 32'(cpu_reset), 32'd1);
        check("n0_busy",           32'(busy),      32'd1);
        idle(1);
        check("n0_cpu_reset_fall", 32'(cpu_reset), 32'd0);
        check("n0_error",          32'(error),     32'd0);
        check("n0_we_total",       32'(we_count),  32'd2);
        pulse_boot();

        // Oversized length (257 > 256)
        send(8'h01); send(8'h01);
        check("big_error",     32'(error),     32'd1);
        check("big_cpu_reset", 32'(cpu_reset), 32'd1);
        check("big_busy",      32'(busy),      32'd0);
        send(8'h55);
        check("err_rx_ready",  32'(rx_ready),  32'd1);
        check("err_error",     32'(error),     32'd1);
        check("big_we_total",  32'(we_count),  32'd2);
        pulse_boot();
        check("big_clr_error", 32'(error),    32'd0);
        check("big_clr_ready", 32'(rx_ready), 32'd1);

        // Idle timeout mid-word
        send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        idle(15);
        check("to_15_error", 32'(error), 32'd0);
        check("to_15_busy",  32'(busy),  32'd1);
        idle(1);
        check("to_16_error",     32'(error),     32'd1);
        check("to_16_cpu_reset", 32'(cpu_reset), 32'd1);
        check("to_we_total",     32'(we_count),  32'd2);
        pulse_boot();

        // Trailing 0xFF: bad checksum, or a byte offered after the image completes
        send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("cs_we",   32'(ram_we),   32'd1);
        check("cs_addr", 32'(ram_addr), 32'd0);
        check("cs_data", ram_wdata,     32'h04030201);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send(8'hFF);
        check("cs_bad_error", 32'(error), 32'd1);
        idle(1);
        check("cs_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`else
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        check("ff_done_ready", 32'(rx_ready), 32'd0);
        idle(1);
        check("ff_run_ready",     32'(rx_ready),  32'd0);
        check("ff_run_cpu_reset", 32'(cpu_reset), 32'd0);
        idle(1);
        check("ff_run_error", 32'(error),      32'd0);
        check("ff_run_count", 32'(word_count), 32'd1);
        rx_valid = 1'b0;
`endif
        check("cs_we_total", 32'(we_count), 32'd3);
        pulse_boot();

        // Asynchronous reset during DATA
        send(8'h03); send(8'h00);
        for (int i = 1; i <= 9; i++) send(8'(i));
        check("ar_count", 32'(word_count), 32'd2);
        check("ar_addr",  32'(ram_addr),   32'd1);
        check("ar_data",  ram_wdata,       32'h08070605);
        check("ar_we_total", 32'(we_count), 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("async");
        #3;
        reset_n = 1'b1;
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
